// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronizes and debounces a 10-key digit pad. It emits a
// single-cycle one-hot pulse, together with the key's BCD code, for each
// accepted press.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while the
// accepted key stays held. Repeat pulses occur every REPEAT_CYCLES cycles.
module keypad_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keys_raw,
    output logic [9:0] keypad,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       busy
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] DEBOUNCE     = 3'd1;
    localparam logic [2:0] PRESSED      = 3'd2;
    localparam logic [2:0] WAIT_RELEASE = 3'd3;
    localparam logic [2:0] LOCKOUT      = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [9:0]  sync_1;
    logic [9:0]  s;
    logic [2:0]  state;
    logic [9:0]  cap_key;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        s_zero;
    logic        s_multi;
    logic        rpt_pulse;
    logic        pulse;
    logic [3:0]  cap_code;

    // Two-flop synchronizer for the asynchronous key switches
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= '0;
            s      <= '0;
        end else begin
            sync_1 <= keys_raw;
            s      <= sync_1;
        end
    end

    // Classify the synchronized keys and form the saturating counter increment
    always_comb begin
        s_zero  = (s == '0);
        s_multi = ((s & (s - 10'd1)) != '0);
        cnt_inc = (cnt == '1) ? cnt : cnt + 16'd1;
    end

    // Debounce FSM: accept a press after a stable one-hot run, then require a stable release
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cap_key <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (s_multi) begin
                        state <= LOCKOUT;
                    end else if (!s_zero) begin
                        state   <= DEBOUNCE;
                        cap_key <= s;
                    end
                end
                DEBOUNCE: begin
                    if (s_multi) begin
                        state <= LOCKOUT;
                        cnt   <= '0;
                    end else if (s != cap_key) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    state <= WAIT_RELEASE;
                    cnt   <= '0;
                end
                WAIT_RELEASE, LOCKOUT: begin
                    if (!s_zero) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
    localparam logic [15:0] RPT_FIRE = 16'(REPEAT_CYCLES - 2);

    logic [15:0] rpt_cnt;

    // Auto-repeat: the counter is zero in the cycle after each pulse, so the
    // pulse flag is raised one count early to land exactly REPEAT_CYCLES apart
    always_ff @(posedge clock) begin
        if (reset || state != WAIT_RELEASE || s != cap_key) begin
            rpt_cnt   <= '0;
            rpt_pulse <= 1'b0;
        end else begin
            rpt_pulse <= (rpt_cnt == RPT_FIRE);
            rpt_cnt   <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 16'd1;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    // Bit index of the captured key
    always_comb begin
        cap_code = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cap_key[i]) cap_code = 4'(i);
        end
    end

    // Output decode: outputs are nonzero only in the pulse cycle
    always_comb begin
        pulse     = (state == PRESSED) || rpt_pulse;
        keypad    = pulse ? cap_key : '0;
        key_code  = pulse ? cap_code : '0;
        key_valid = pulse;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: a directed-vector scoreboard bench for keypad_debounce
// that uses the default parameters (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64).
// Expected pulses record the cycle counter value that the negedge monitor
// must observe.
module tb_keypad_debounce;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keys_raw;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;
    logic       busy;

    typedef struct {
        int         at;
        logic [9:0] kp;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_valid = 1'b0;

    keypad_debounce #(.DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(64)) dut (
        .clock    (clock),
        .reset    (reset),
        .keys_raw (keys_raw),
        .keypad   (keypad),
        .key_code (key_code),
        .key_valid(key_valid),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [9:0] kp, input logic [3:0] code);
        exp_t e;
        e.at   = at;
        e.kp   = kp;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        fork
            // Monitor: pops an expected entry for every pulse the DUT presents
            forever begin
                @(negedge clock);
                chk("valid_vs_keypad", 32'(keypad != '0), 32'(key_valid));
                if (key_valid) begin
                    chk("back_to_back", 32'(prev_valid), 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse_keypad", 32'(keypad), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("pulse_cycle", 32'(cyc), 32'(e.at));
                        chk("pulse_keypad", 32'(keypad), 32'(e.kp));
                        chk("pulse_code", 32'(key_code), 32'(e.code));
                    end
                end
                prev_valid = key_valid;
            end
        join_none

        // Reset state
        reset    = 1'b1;
        keys_raw = '0;
        step(3);
        chk("rst_keypad", 32'(keypad), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // Key 3 held 40 cycles: one pulse 19 edges after the stimulus edge
        keys_raw = 10'b0000001000;
        expect_pulse(cyc + 19, 10'b0000001000, 4'd3);
        step(5);
        chk("busy_debounce", 32'(busy), 32'd1);
        step(35);
        keys_raw = '0;
        wait_idle("idle_after_key3", 100);

        // Key 5 bouncing 5 on / 3 off, six times: no pulse
        repeat (6) begin
            keys_raw = 10'b0000100000;
            step(5);
            keys_raw = '0;
            step(3);
        end
        wait_idle("idle_after_bounce", 100);

        // Key 6 glitch of 15 cycles, shorter than the debounce window: no pulse
        keys_raw = 10'b0001000000;
        step(15);
        keys_raw = '0;
        wait_idle("idle_after_glitch", 100);

        // Keys 2 and 7 together lock out; key 7 alone afterwards is accepted
        keys_raw = 10'b0010000100;
        step(5);
        chk("busy_lockout", 32'(busy), 32'd1);
        step(45);
        keys_raw = '0;
        step(20);
        keys_raw = 10'b0010000000;
        expect_pulse(cyc + 19, 10'b0010000000, 4'd7);
        step(40);
        keys_raw = '0;
        wait_idle("idle_after_key7", 100);

        // Key 9 held, and reset pulsed mid-debounce: pulse only after reset release
        keys_raw = 10'b1000000000;
        step(12);
        reset = 1'b1;
        step(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(key_valid), 32'd0);
        reset = 1'b0;
        expect_pulse(cyc + 19, 10'b1000000000, 4'd9);
        step(40);
        keys_raw = '0;
        wait_idle("idle_after_key9", 100);

        // Key 4 accepted; then extra keys during the release wait produce nothing
        keys_raw = 10'b0000010000;
        expect_pulse(cyc + 19, 10'b0000010000, 4'd4);
        step(30);
        keys_raw = 10'b0000010010;
        step(20);
        keys_raw = 10'b0000000010;
        step(20);
        chk("busy_wait_release", 32'(busy), 32'd1);
        keys_raw = '0;
        wait_idle("idle_after_key4", 100);

        // Key 0 held 300 cycles: one pulse, plus four repeats when auto-repeat is built in
        begin
            int base;
            base = cyc;
            keys_raw = 10'b0000000001;
            expect_pulse(base + 19, 10'b0000000001, 4'd0);
`ifdef KEYPAD_REPEAT_EN
            for (int k = 1; k <= 4; k++) expect_pulse(base + 19 + 64 * k, 10'b0000000001, 4'd0);
`endif
            step(300);
            keys_raw = '0;
            wait_idle("idle_after_key0", 100);
        end

        step(5);
        chk("missing_pulses", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
